ps2_note_decoder: RTL

- Front end that produces the note-event interface consumed by the synth ALU controller: `note_in`, `note[3:0]` and `octave[2:0]`.
- Receives PS/2 keyboard frames and decodes make (key-press) and break (key-release) scancodes into note events.
- Tracks a current octave, adjusted from two dedicated keys.
- Issues a one-cycle `note_in` pulse with stable `note`/`octave` whenever a new musical key is pressed.

---
 rtl/ps2_note_decoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard front end: receives scancode frames and turns make/break codes
// into note events (note_in pulse, note, octave) for the synth controller.
module ps2_note_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEFAULT_OCTAVE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       note_in,
  output logic [3:0] note,
  output logic [2:0] octave,
  output logic       key_held,
  output logic       frame_err
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_t;

  // Synchroniser and edge-detect flops idle high, matching the PS/2 bus idle level
  logic ps2_clk_s1_q, ps2_clk_s1_d, ps2_clk_s2_q, ps2_clk_s2_d;
  logic ps2_clk_prev_q, ps2_clk_prev_d;
  logic ps2_dat_s1_q, ps2_dat_s1_d, ps2_dat_s2_q, ps2_dat_s2_d;
  logic ps2_fall;

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;

  dec_state_t    state_q, state_d;
  logic [3:0]    note_q, note_d;
  logic [2:0]    octave_q, octave_d;
  logic          note_in_q, note_in_d;
  logic          key_held_q, key_held_d;
  logic [7:0]    held_code_q, held_code_d;

  logic          key_hit;
  logic [3:0]    key_note;

  always_comb begin
    ps2_clk_s1_d   = ps2_clk;
    ps2_clk_s2_d   = ps2_clk_s1_q;
    ps2_clk_prev_d = ps2_clk_s2_q;
    ps2_dat_s1_d   = ps2_dat;
    ps2_dat_s2_d   = ps2_dat_s1_q;
  end

  assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

  // Frame receiver: bit_cnt 0 = idle, 1..9 = d0..d7 and parity, 10 = stop bit
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;
    if (ps2_fall) begin
      idle_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!ps2_dat_s2_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q < 4'd10) begin
        shift_d   = {ps2_dat_s2_q, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        bit_cnt_d = 4'd0;
        if (ps2_dat_s2_q && (^shift_q)) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = 4'd0;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    key_hit  = 1'b1;
    key_note = 4'd0;
    case (byte_q)
      8'h1C: key_note = 4'd0;
      8'h1D: key_note = 4'd1;
      8'h1B: key_note = 4'd2;
      8'h24: key_note = 4'd3;
      8'h23: key_note = 4'd4;
      8'h2B: key_note = 4'd5;
      8'h2C: key_note = 4'd6;
      8'h34: key_note = 4'd7;
      8'h35: key_note = 4'd8;
      8'h33: key_note = 4'd9;
      8'h3C: key_note = 4'd10;
      8'h3B: key_note = 4'd11;
      default: key_hit = 1'b0;
    endcase
  end

  // Decoder advances only on accepted bytes; discarded frames never reach it
  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    octave_d    = octave_q;
    note_in_d   = 1'b0;
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    if (byte_valid_q) begin
      case (state_q)
        ST_NORMAL: begin
          if (byte_q == 8'hF0) begin
            state_d = ST_BREAK;
          end else if (byte_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (key_hit) begin
            // Typematic repeats of the held key produce no new event
            if (!key_held_q || (byte_q != held_code_q)) begin
              note_d      = key_note;
              key_held_d  = 1'b1;
              held_code_d = byte_q;
              note_in_d   = 1'b1;
            end
          end else if (byte_q == 8'h1A) begin
            if (octave_q != 3'd0) octave_d = octave_q - 3'd1;
          end else if (byte_q == 8'h22) begin
            if (octave_q < 3'd6) octave_d = octave_q + 3'd1;
          end
        end
        ST_BREAK: begin
          if (byte_q == held_code_q) key_held_d = 1'b0;
          state_d = ST_NORMAL;
        end
        ST_EXT: begin
          state_d = (byte_q == 8'hF0) ? ST_EXT_BREAK : ST_NORMAL;
        end
        default: begin
          state_d = ST_NORMAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_dat_s1_q   <= 1'b1;
      ps2_dat_s2_q   <= 1'b1;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 9'd0;
      idle_cnt_q     <= '0;
      byte_valid_q   <= 1'b0;
      byte_q         <= 8'd0;
      frame_err_q    <= 1'b0;
      state_q        <= ST_NORMAL;
      note_q         <= 4'd0;
      octave_q       <= 3'(DEFAULT_OCTAVE);
      note_in_q      <= 1'b0;
      key_held_q     <= 1'b0;
      held_code_q    <= 8'd0;
    end else begin
      ps2_clk_s1_q   <= ps2_clk_s1_d;
      ps2_clk_s2_q   <= ps2_clk_s2_d;
      ps2_clk_prev_q <= ps2_clk_prev_d;
      ps2_dat_s1_q   <= ps2_dat_s1_d;
      ps2_dat_s2_q   <= ps2_dat_s2_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      idle_cnt_q     <= idle_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_q         <= byte_d;
      frame_err_q    <= frame_err_d;
      state_q        <= state_d;
      note_q         <= note_d;
      octave_q       <= octave_d;
      note_in_q      <= note_in_d;
      key_held_q     <= key_held_d;
      held_code_q    <= held_code_d;
    end
  end

  assign note_in   = note_in_q;
  assign note      = note_q;
  assign octave    = octave_q;
  assign key_held  = key_held_q;
  assign frame_err = frame_err_q;

endmodule
